io_supply_sequencer: RTL
========================

# io_supply_sequencer

Parametrised IO-ring supply sequencer for the GF22FDX IO library. It powers up N_CH VDDQ/VSSQ pad segments in order: enable the segment switch, wait for a debounced power-good, then release the isolation clamp. Power-down runs in reverse order. Supply faults are detected, reported and fully clamped. The block sits in the always-on digital domain next to the IO ring and drives pad-segment switch enables and clamp controls.

## Interface
- N_CH, 4: number of pad supply segments; must be at least 1.
- SETTLE_CYC, 16: consecutive synchronised cycles with pg stable before a segment is declared settled; must be at least 1.
- TIMEOUT_CYC, 1024: maximum cycles per segment step before a fault; must be greater than SETTLE_CYC+2.
- clk_i  in  1  single block clock.
- rst_i  in  1  reset, synchronous, active-high.
- pwr_req_i  in  1  level request: 1 = ring powered, 0 = ring off.
- pg_i  in  N_CH  asynchronous per-segment power-good from the pad supply detectors.
- en_o  out  N_CH  segment supply-switch enable.
- iso_o  out  N_CH  segment isolation clamp; 1 = clamped.
- ready_o  out  1  all segments on and unclamped.
- busy_o  out  1  sequencing in progress (UP_WAIT, DN_ISO, DN_WAIT).
- fault_o  out  1  latched fault flag.
- fault_ch_o  out  max(1,$clog2(N_CH))  index of the segment that faulted.

## Operation
- pg_i passes through a 2-flop synchroniser per bit. pgs denotes the synchronised value.
- States:
  - OFF: all en_o=0, all iso_o=1.
  - UP_WAIT
  - ON
  - DN_ISO
  - DN_WAIT
  - FAULT
- Channel index k selects the current segment. The settle counter counts consecutive cycles with pgs[k] at its target level and clears whenever pgs[k] leaves that level. The timeout counter counts cycles spent in the current step.
- OFF, pwr_req_i=1 → UP_WAIT with k=0 and en_o[0]=1.
- UP_WAIT, settle count reaches SETTLE_CYC with pgs[k]=1 → iso_o[k]=0.
  - If k<N_CH-1: k+1, en_o[k+1]=1, counters cleared.
  - If k=N_CH-1: go to ON.
- UP_WAIT, timeout count reaches TIMEOUT_CYC → FAULT.
- UP_WAIT, pwr_req_i=0 → abort and go to DN_ISO at the current k. Segments above k are untouched.
- ON: ready_o=1.
  - pgs[j]=0 on any channel j → FAULT, with fault_ch_o = lowest such j.
  - pwr_req_i=0 → DN_ISO with k=N_CH-1.
- DN_ISO, one cycle: iso_o[k]=1, then DN_WAIT with en_o[k]=0.
- DN_WAIT, settle count reaches SETTLE_CYC with pgs[k]=0:
  - If k>0: k-1, go to DN_ISO.
  - If k=0: go to OFF.
- DN_WAIT, timeout → FAULT.
- pwr_req_i rising during DN_ISO or DN_WAIT is ignored until OFF is reached. Because the request is a level, power-up restarts from OFF on the next cycle.
- FAULT:
  - all en_o=0, all iso_o=1, fault_o=1, fault_ch_o = k (or j, for a fault from ON).
  - Leaves to OFF only on a cycle with pwr_req_i=0. fault_o clears on that transition.
  - While pwr_req_i stays 1, the block stays in FAULT. No auto-retry.
- Counter widths:
  - settle counter: $clog2(SETTLE_CYC+1)
  - timeout counter: $clog2(TIMEOUT_CYC+1)
  - Both saturate and never wrap.

## Timing
- All outputs are registered.
- Reset values: en_o=0, iso_o all 1, ready_o=0, busy_o=0, fault_o=0, fault_ch_o=0, state OFF, k=0, counters 0.
- pwr_req_i sampled 1 in OFF at edge t → en_o[0]=1 and busy_o=1 from t+1.
- pg_i edge to pgs: 2 cycles.
- Settle: iso_o[k] falls and en_o[k+1] rises in the same cycle, SETTLE_CYC cycles after pgs[k] first stays high.
- Minimum power-up for one segment: 1 + 2 + SETTLE_CYC cycles from request to iso release.
- ON → FAULT: 1 cycle after pgs drops, so 3 cycles after pg_i drops.
- DN_ISO to en_o fall is exactly 1 cycle. The clamp is always applied before the switch opens.
- Timeout and settle reached in the same cycle: settle wins.
- pwr_req_i=0 in the same cycle as the final settle: ON is entered first, and power-down follows on the next sampled cycle.
- rst_i mid-operation: all outputs return to reset values on the next edge. Segments are clamped and disabled immediately.

## Structure
- io_supply_seq_pkg:
  - state enum (OFF, UP_WAIT, ON, DN_ISO, DN_WAIT, FAULT)
  - counter-width helper functions
  - elaboration-time parameter checks
- Sub-module io_sync_2ff, instantiated N_CH wide for pg_i. It is reusable across the IO digital blocks.
- FSM, k index and both counters live in io_supply_sequencer.

## Test plan
All scenarios use N_CH=4, SETTLE_CYC=16, TIMEOUT_CYC=1024.
- Nominal up: pwr_req_i=1, with each pg_i rising 5 cycles after its en_o → en_o 0001→1111 in order, each iso_o release 18 cycles after its pg_i rise, ready_o=1 after the 4th release.
- Glitch: pg_i[1] high 10 cycles, low 1 cycle, then high → settle restarts, iso_o[1] stays 1 until 16 clean synced cycles have elapsed.
- Timeout: pg_i[2] never rises → FAULT exactly 1024 cycles after en_o[2]=1, fault_ch_o=2, en_o=0000, iso_o=1111, ready_o=0.
- Runtime loss: in ON, drop pg_i[3] → fault_o=1 3 cycles later, fault_ch_o=3. Holding pwr_req_i=1 keeps FAULT; pwr_req_i=0 → OFF with fault_o=0.
- Abort and restart: pwr_req_i falls while k=1 in UP_WAIT → DN_ISO at k=1, then k=0, then OFF. pwr_req_i rises during DN_WAIT → OFF is reached first, and en_o[0] re-asserts on the next cycle.
- Reset mid-power-up: rst_i pulse with k=2 → next cycle en_o=0000, iso_o=1111, busy_o=0.

Source files
------------

// File: rtl/io_supply_seq_pkg.sv
// Shared types and elaboration helpers for the IO-ring supply sequencer.
package io_supply_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    UP_WAIT,
    ON,
    DN_ISO,
    DN_WAIT,
    FAULT
  } seq_state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned settle,
                                   input int unsigned tmo);
    return (n >= 1) && (settle >= 1) && (tmo > settle + 2);
  endfunction

endpackage

// File: rtl/io_sync_2ff.sv
// Plain two-flop synchroniser, reusable across the IO digital blocks.
module io_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= '0;
      q_o  <= '0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/io_supply_sequencer.sv
// Sequences N_CH pad supply segments up (enable, settle, unclamp) and down
// (clamp, disable, settle) in order, with latched fault handling.
module io_supply_sequencer
  import io_supply_seq_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pwr_req_i,
  input  logic [N_CH-1:0]       pg_i,
  output logic [N_CH-1:0]       en_o,
  output logic [N_CH-1:0]       iso_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [ch_w(N_CH)-1:0] fault_ch_o
);

  localparam int unsigned CW = ch_w(N_CH);
  localparam int unsigned SW = cnt_w(SETTLE_CYC);
  localparam int unsigned TW = cnt_w(TIMEOUT_CYC);

  localparam logic [CW-1:0] K_LAST   = CW'(N_CH - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SET_MAX  = SW'(SETTLE_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

  if (!params_ok(N_CH, SETTLE_CYC, TIMEOUT_CYC)) begin : g_param_check
    $error("io_supply_sequencer: invalid N_CH/SETTLE_CYC/TIMEOUT_CYC");
  end

  logic [N_CH-1:0] pgs;

  io_sync_2ff #(.WIDTH(N_CH)) u_pg_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pg_i),
    .q_o   (pgs)
  );

  seq_state_e      state_q, state_d;
  logic [CW-1:0]   k_q, k_d, lost_ch, fch_d;
  logic [SW-1:0]   set_q, set_d, set_inc;
  logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [N_CH-1:0] en_d, iso_d;
  logic            ready_d, busy_d, fault_d;
  logic            at_target, settled, timed_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= OFF;
      k_q        <= '0;
      set_q      <= '0;
      tmo_q      <= '0;
      en_o       <= '0;
      iso_o      <= '1;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      fault_o    <= 1'b0;
      fault_ch_o <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      set_q      <= set_d;
      tmo_q      <= tmo_d;
      en_o       <= en_d;
      iso_o      <= iso_d;
      ready_o    <= ready_d;
      busy_o     <= busy_d;
      fault_o    <= fault_d;
      fault_ch_o <= fch_d;
    end
  end

  always_comb begin
    // Target level is high while powering up, low while draining.
    at_target = (state_q == DN_WAIT) ? !pgs[k_q] : pgs[k_q];
    set_inc   = at_target ? ((set_q == SET_MAX) ? set_q : set_q + SW'(1)) : '0;
    tmo_inc   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
    settled   = at_target && (set_q >= SET_LAST);
    timed_out = (tmo_q >= TMO_LAST);

    lost_ch = '0;
    for (int unsigned j = N_CH; j > 0; j--) begin
      if (!pgs[j-1]) lost_ch = CW'(j - 1);
    end

    state_d = state_q;
    k_d     = k_q;
    set_d   = set_inc;
    tmo_d   = tmo_inc;
    en_d    = en_o;
    iso_d   = iso_o;
    fch_d   = fault_ch_o;

    case (state_q)
      OFF: begin
        k_d   = '0;
        set_d = '0;
        tmo_d = '0;
        en_d  = '0;
        iso_d = '1;
        if (pwr_req_i) begin
          state_d = UP_WAIT;
          en_d[0] = 1'b1;
        end
      end
      UP_WAIT: begin
        // Settle beats both abort and timeout on the same cycle.
        if (settled) begin
          iso_d[k_q] = 1'b0;
          set_d      = '0;
          tmo_d      = '0;
          if (k_q == K_LAST) begin
            state_d = ON;
          end else begin
            k_d                 = k_q + CW'(1);
            en_d[k_q + CW'(1)]  = 1'b1;
          end
        end else if (!pwr_req_i) begin
          state_d    = DN_ISO;
          iso_d[k_q] = 1'b1;
          set_d      = '0;
          tmo_d      = '0;
        end else if (timed_out) begin
          state_d = FAULT;
          fch_d   = k_q;
        end
      end
      ON: begin
        set_d = '0;
        tmo_d = '0;
        if (pgs != '1) begin
          state_d = FAULT;
          fch_d   = lost_ch;
        end else if (!pwr_req_i) begin
          state_d       = DN_ISO;
          k_d           = K_LAST;
          iso_d[K_LAST] = 1'b1;
        end
      end
      DN_ISO: begin
        state_d   = DN_WAIT;
        en_d[k_q] = 1'b0;
        set_d     = '0;
        tmo_d     = '0;
      end
      DN_WAIT: begin
        if (settled) begin
          set_d = '0;
          tmo_d = '0;
          if (k_q == '0) begin
            state_d = OFF;
          end else begin
            state_d             = DN_ISO;
            k_d                 = k_q - CW'(1);
            iso_d[k_q - CW'(1)] = 1'b1;
          end
        end else if (timed_out) begin
          state_d = FAULT;
          fch_d   = k_q;
        end
      end
      FAULT: begin
        set_d = '0;
        tmo_d = '0;
        if (!pwr_req_i) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    if (state_d == FAULT) begin
      en_d  = '0;
      iso_d = '1;
    end
    ready_d = (state_d == ON);
    busy_d  = (state_d == UP_WAIT) || (state_d == DN_ISO) || (state_d == DN_WAIT);
    fault_d = (state_d == FAULT);
  end

endmodule
